regfile_wr_arbiter: RTL

- Shares the single register-file write port between two requesters.
  - Port A: LFSR operand loader.
  - Port B: ALU result writeback.
- Round-robin arbitration, one write per cycle maximum.
- Built-in clear engine zeroes every register after reset or on command, with absolute priority over both requesters.
- Sits between the sequencing FSM / datapath sources and the register file write port (we, waddr, wdata).

---
 rtl/regfile_wr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: round-robin between the LFSR loader (A) and
// the ALU writeback (B), with a clear engine that sweeps zeroes over every entry.
module regfile_wr_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic {
    S_CLEAR,
    S_ARB
  } state_t;

  state_t state_q, state_d;

  // One extra bit so the sweep can tell "all DEPTH entries written" apart from entry 0.
  logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d;
  logic              last_b_q, last_b_d;

  logic              gnt_a_d, gnt_b_d, we_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              clr_busy_d, clr_done_d;
  logic [7:0]        cnt_d;

  logic              elig_a, elig_b, pick_a, pick_b;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    last_b_d   = last_b_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    we_d       = 1'b0;
    waddr_d    = waddr;
    wdata_d    = wdata;
    clr_busy_d = clr_busy;
    clr_done_d = 1'b0;
    cnt_d      = conflict_cnt;

    // A requester being granted this cycle is still holding req; skip it once.
    elig_a = req_a & ~gnt_a;
    elig_b = req_b & ~gnt_b;
    pick_a = elig_a & (~elig_b | last_b_q);
    pick_b = elig_b & ~pick_a;

    case (state_q)
      S_CLEAR: begin
        if (clr_ptr_q[ADDR_W]) begin
          state_d    = S_ARB;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
        end else begin
          we_d      = 1'b1;
          waddr_d   = clr_ptr_q[ADDR_W-1:0];
          wdata_d   = '0;
          clr_ptr_d = clr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
        end
      end

      S_ARB: begin
        if (clr_req) begin
          state_d    = S_CLEAR;
          clr_ptr_d  = '0;
          clr_busy_d = 1'b1;
          cnt_d      = '0;
        end else begin
          if (elig_a && elig_b && (conflict_cnt != 8'hFF))
            cnt_d = conflict_cnt + 8'd1;
          if (pick_a) begin
            gnt_a_d  = 1'b1;
            we_d     = 1'b1;
            waddr_d  = addr_a;
            wdata_d  = data_a;
            last_b_d = 1'b0;
          end else if (pick_b) begin
            gnt_b_d  = 1'b1;
            we_d     = 1'b1;
            waddr_d  = addr_b;
            wdata_d  = data_b;
            last_b_d = 1'b1;
          end
        end
      end

      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CLEAR;
      clr_ptr_q    <= '0;
      last_b_q     <= 1'b1;
      gnt_a        <= 1'b0;
      gnt_b        <= 1'b0;
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      clr_busy     <= 1'b1;
      clr_done     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      last_b_q     <= last_b_d;
      gnt_a        <= gnt_a_d;
      gnt_b        <= gnt_b_d;
      we           <= we_d;
      waddr        <= waddr_d;
      wdata        <= wdata_d;
      clr_busy     <= clr_busy_d;
      clr_done     <= clr_done_d;
      conflict_cnt <= cnt_d;
    end
  end

endmodule
